// File: rtl/pcie_ts_rx_decoder.sv
// pcie_ts_rx_decoder_pkg / pcie_ts_rx_decoder
//
// Per-lane receive-side TS1/TS2 ordered-set decoder. It consumes the lane's
// descrambled, symbol-aligned receive stream, four symbols per beat with
// per-byte K flags. A complete, well-formed 16-symbol training set produces
// a one-cycle ts1/ts2 pulse. The captured fields update in the same cycle.
// A malformed or aborted set produces a one-cycle ts_error_o pulse.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   en_i                decoder enable (low: back to hunt, no pulses)
//   s_axis_tdata/tk     symbols (byte 0 earliest) and per-byte K flags
//   s_axis_tvalid       beat valid
//   s_axis_tready       high whenever out of reset
//   ts1_valid_o         pulse, TS1 received
//   ts2_valid_o         pulse, TS2 received
//   link_num_o .. training_ctrl_o   fields of the last valid TS
//   ts_error_o          pulse, malformed or aborted ordered set

package pcie_ts_rx_decoder_pkg;
    // Training control symbol (symbol 5), bit 0 first.
    typedef struct packed {
        logic [2:0] reserved;
        logic       compliance_receive;
        logic       disable_scrambling;
        logic       loopback;
        logic       disable_link;
        logic       hot_reset;
    } training_ctrl_t;
endpackage

module pcie_ts_rx_decoder
    import pcie_ts_rx_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tk,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  ts1_valid_o,
    output logic                  ts2_valid_o,
    output logic [7:0]            link_num_o,
    output logic [7:0]            lane_num_o,
    output logic [7:0]            n_fts_o,
    output logic [7:0]            rate_id_o,
    output training_ctrl_t        training_ctrl_o,
    output logic                  ts_error_o
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("pcie_ts_rx_decoder: only DATA_WIDTH = 32 is supported");
    end

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam logic [7:0] PAD_SYM = 8'hF7;
    localparam logic [7:0] TS1_ID  = 8'h4A;
    localparam logic [7:0] TS2_ID  = 8'h45;

    typedef enum logic [1:0] {ST_HUNT, ST_W1, ST_W2, ST_W3} state_t;

    state_t         state_q, state_d;
    logic [7:0]     link_q, link_d, lane_q, lane_d, nfts_q, nfts_d;
    logic [7:0]     rate_q, rate_d;
    training_ctrl_t tctrl_q, tctrl_d;
    logic           fields_ok_q, fields_ok_d;
    logic           is_ts2_q, is_ts2_d;
    logic           ts1_q, ts1_d, ts2_q, ts2_d, err_q, err_d;
    logic [7:0]     link_out_q, link_out_d, lane_out_q, lane_out_d;
    logic [7:0]     nfts_out_q, nfts_out_d, rate_out_q, rate_out_d;
    training_ctrl_t tctrl_out_q, tctrl_out_d;

    logic [7:0] sym0_s, sym1_s, sym2_s, sym3_s, ident_s;
    logic       accept_s, is_com_s, start_ok_s, all_data_s;
    logic       w1_ok_s, id_run_s, load_start_s;

    // Ready is only withheld while reset is applied.
    assign s_axis_tready = ~rst_i;

    assign sym0_s   = s_axis_tdata[7:0];
    assign sym1_s   = s_axis_tdata[15:8];
    assign sym2_s   = s_axis_tdata[23:16];
    assign sym3_s   = s_axis_tdata[31:24];
    assign accept_s = s_axis_tvalid & s_axis_tready & en_i;
    assign is_com_s = (sym0_s == COM_SYM) & s_axis_tk[0];
    // Link/lane may be any data value or a PAD K-symbol; N_FTS must be data.
    assign start_ok_s = (~s_axis_tk[1] | (sym1_s == PAD_SYM))
                      & (~s_axis_tk[2] | (sym2_s == PAD_SYM))
                      & ~s_axis_tk[3];
    assign all_data_s = (s_axis_tk == {KEEP_WIDTH{1'b0}});
    assign ident_s    = is_ts2_q ? TS2_ID : TS1_ID;
    assign w1_ok_s    = all_data_s & ((sym2_s == TS1_ID) | (sym2_s == TS2_ID))
                      & (sym3_s == sym2_s);
    assign id_run_s   = all_data_s & (sym0_s == ident_s) & (sym1_s == ident_s)
                      & (sym2_s == ident_s) & (sym3_s == ident_s);

    // Next-state, field capture and output pulse logic.
    always_comb begin
        state_d      = state_q;
        link_d       = link_q;
        lane_d       = lane_q;
        nfts_d       = nfts_q;
        rate_d       = rate_q;
        tctrl_d      = tctrl_q;
        fields_ok_d  = fields_ok_q;
        is_ts2_d     = is_ts2_q;
        ts1_d        = 1'b0;
        ts2_d        = 1'b0;
        err_d        = 1'b0;
        link_out_d   = link_out_q;
        lane_out_d   = lane_out_q;
        nfts_out_d   = nfts_out_q;
        rate_out_d   = rate_out_q;
        tctrl_out_d  = tctrl_out_q;
        load_start_s = 1'b0;

        if (!en_i) begin
            state_d = ST_HUNT;
        end else if (accept_s) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_com_s) begin
                        load_start_s = 1'b1;
                        state_d      = ST_W1;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_W1: begin
                    if (w1_ok_s) begin
                        rate_d   = sym0_s;
                        tctrl_d  = training_ctrl_t'(sym1_s);
                        is_ts2_d = (sym2_s == TS2_ID);
                        state_d  = ST_W2;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_W2: begin
                    if (id_run_s) begin
                        state_d = ST_W3;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_W3: begin
                    if (id_run_s && fields_ok_q) begin
                        ts1_d       = ~is_ts2_q;
                        ts2_d       = is_ts2_q;
                        link_out_d  = link_q;
                        lane_out_d  = lane_q;
                        nfts_out_d  = nfts_q;
                        rate_out_d  = rate_q;
                        tctrl_out_d = tctrl_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_HUNT;
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase

            // A failing beat that is itself a COM restarts a set immediately.
            if (err_d && (state_q != ST_HUNT)) begin
                if (is_com_s) begin
                    load_start_s = 1'b1;
                    state_d      = ST_W1;
                end else begin
                    state_d = ST_HUNT;
                end
            end else begin
                load_start_s = load_start_s;
            end
        end else begin
            state_d = state_q;
        end

        if (load_start_s) begin
            link_d      = sym1_s;
            lane_d      = sym2_s;
            nfts_d      = sym3_s;
            fields_ok_d = start_ok_s;
        end else begin
            fields_ok_d = fields_ok_d;
        end
    end

    // State, partial-set latches and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_HUNT;
            link_q      <= 8'h00;
            lane_q      <= 8'h00;
            nfts_q      <= 8'h00;
            rate_q      <= 8'h00;
            tctrl_q     <= training_ctrl_t'(8'h00);
            fields_ok_q <= 1'b0;
            is_ts2_q    <= 1'b0;
            ts1_q       <= 1'b0;
            ts2_q       <= 1'b0;
            err_q       <= 1'b0;
            link_out_q  <= PAD_SYM;
            lane_out_q  <= PAD_SYM;
            nfts_out_q  <= 8'h00;
            rate_out_q  <= 8'h00;
            tctrl_out_q <= training_ctrl_t'(8'h00);
        end else begin
            state_q     <= state_d;
            link_q      <= link_d;
            lane_q      <= lane_d;
            nfts_q      <= nfts_d;
            rate_q      <= rate_d;
            tctrl_q     <= tctrl_d;
            fields_ok_q <= fields_ok_d;
            is_ts2_q    <= is_ts2_d;
            ts1_q       <= ts1_d;
            ts2_q       <= ts2_d;
            err_q       <= err_d;
            link_out_q  <= link_out_d;
            lane_out_q  <= lane_out_d;
            nfts_out_q  <= nfts_out_d;
            rate_out_q  <= rate_out_d;
            tctrl_out_q <= tctrl_out_d;
        end
    end

    assign ts1_valid_o     = ts1_q;
    assign ts2_valid_o     = ts2_q;
    assign ts_error_o      = err_q;
    assign link_num_o      = link_out_q;
    assign lane_num_o      = lane_out_q;
    assign n_fts_o         = nfts_out_q;
    assign rate_id_o       = rate_out_q;
    assign training_ctrl_o = tctrl_out_q;

endmodule
